// File: rtl/skip_addr_seq_pkg.sv
// Shared types and geometry helpers for the skip-BRAM address sequencers.
package skip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Tiles per row of the feature map.
  function automatic int unsigned tpr(input int unsigned map_dim, input int unsigned tile_dim);
    return map_dim / tile_dim;
  endfunction

  // Number of horizontally adjacent tile pairs in the map.
  function automatic int unsigned npair(input int unsigned map_dim, input int unsigned tile_dim);
    return (tpr(map_dim, tile_dim) * tpr(map_dim, tile_dim)) / 2;
  endfunction

  // Coordinate width for one map axis.
  function automatic int unsigned cw(input int unsigned map_dim);
    return int'($clog2(map_dim));
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : int'($clog2(v));
  endfunction

endpackage

// File: rtl/skip_tile_cnt.sv
// Nested tile-pair / row / column counter: y innermost, then x, then t.
module skip_tile_cnt
  import skip_pkg::*;
#(
  parameter int unsigned TILE_DIM = 8,
  parameter int unsigned NPAIR    = 8,
  parameter int unsigned XW       = clog2_min1(TILE_DIM),
  parameter int unsigned TW       = clog2_min1(NPAIR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [TW-1:0] t_q,
  output logic [XW-1:0] x_q,
  output logic [XW-1:0] y_q,
  output logic          y_tc,
  output logic          x_tc,
  output logic          t_tc
);

  logic [TW-1:0] t_d;
  logic [XW-1:0] x_d;
  logic [XW-1:0] y_d;

  assign y_tc = (y_q == XW'(TILE_DIM - 1));
  assign x_tc = (x_q == XW'(TILE_DIM - 1));
  assign t_tc = (t_q == TW'(NPAIR - 1));

  // Next-count: column wrap steps the row, row wrap steps the tile pair.
  always_comb begin
    t_d = t_q;
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      t_d = '0;
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (y_tc) begin
        y_d = '0;
        if (x_tc) begin
          x_d = '0;
          t_d = t_tc ? '0 : t_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      t_q <= t_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/skip_addr_seq.sv
// Sequential skip-BRAM address generator with BRAM2 bypass outside a pass.
module skip_addr_seq
  import skip_pkg::*;
#(
  parameter int unsigned MAP_DIM  = 32,
  parameter int unsigned TILE_DIM = 8,
  parameter int unsigned CW       = cw(MAP_DIM),
  parameter int unsigned ADDR_W   = 2 * CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  input  logic [ADDR_W-1:0] byp_addr1,
  input  logic [ADDR_W-1:0] byp_addr2,
  output logic [ADDR_W-1:0] skip_addr1,
  output logic [ADDR_W-1:0] skip_addr2,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TPR      = tpr(MAP_DIM, TILE_DIM);
  localparam int unsigned NPAIR    = npair(MAP_DIM, TILE_DIM);
  localparam int unsigned HALF     = TPR / 2;
  localparam int unsigned HALF_LOG = int'($clog2(HALF));
  localparam int unsigned TW       = clog2_min1(NPAIR);
  localparam int unsigned XW       = clog2_min1(TILE_DIM);

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          cnt_clr, cnt_en, cnt_last;
  logic          y_tc, x_tc, t_tc;
  logic [TW-1:0] t_q;
  logic [XW-1:0] x_q, y_q;

  logic [CW-1:0] xt, yp, row, col1, col2;

  skip_tile_cnt #(
    .TILE_DIM (TILE_DIM),
    .NPAIR    (NPAIR),
    .XW       (XW),
    .TW       (TW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .t_q  (t_q),
    .x_q  (x_q),
    .y_q  (y_q),
    .y_tc (y_tc),
    .x_tc (x_tc),
    .t_tc (t_tc)
  );

  assign cnt_last = t_tc & x_tc & y_tc;

  // Address arithmetic from the registered counters; HALF is a power of 2,
  // so the divide/modulo by TPR/2 reduce to a shift and a mask.
  always_comb begin
    xt   = CW'(t_q >> HALF_LOG);
    yp   = CW'(t_q & TW'(HALF - 1));
    row  = xt * CW'(TILE_DIM) + CW'(x_q);
    col1 = (yp << 1) * CW'(TILE_DIM) + CW'(y_q);
    col2 = col1 + CW'(TILE_DIM);
  end

  // FSM next-state and registered status outputs.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (out_ready) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Output mux: sequenced pair during a pass, BRAM2 bypass otherwise.
  always_comb begin
    if (valid_q) begin
      skip_addr1 = {row, col1};
      skip_addr2 = {row, col2};
    end else begin
      skip_addr1 = byp_addr1;
      skip_addr2 = byp_addr2;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = valid_q & cnt_last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_skip_addr_seq.sv
// Directed self-checking bench for skip_addr_seq (32/8 and 16/4 instances).
module tb_skip_addr_seq;

  logic       clk;
  logic       rst;
  logic       start, out_ready;
  logic [9:0] byp1, byp2, skip1, skip2;
  logic       valid, last, busy, done;

  logic       start_b, ready_b;
  logic [7:0] byp1_b, byp2_b, skip1_b, skip2_b;
  logic       valid_b, last_b, busy_b, done_b;

  int total;
  int bad;

  skip_addr_seq #(.MAP_DIM(32), .TILE_DIM(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .out_ready  (out_ready),
    .byp_addr1  (byp1),
    .byp_addr2  (byp2),
    .skip_addr1 (skip1),
    .skip_addr2 (skip2),
    .out_valid  (valid),
    .out_last   (last),
    .busy       (busy),
    .done       (done)
  );

  skip_addr_seq #(.MAP_DIM(16), .TILE_DIM(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .out_ready  (ready_b),
    .byp_addr1  (byp1_b),
    .byp_addr2  (byp2_b),
    .skip_addr1 (skip1_b),
    .skip_addr2 (skip2_b),
    .out_valid  (valid_b),
    .out_last   (last_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    byp1 = 10'h155;
    byp2 = 10'h2AA;
    do_reset();
    total++; if (skip1 !== 10'h155) begin bad++; $display("FAIL reset_skip1 got=%0h exp=155", skip1); end
    total++; if (skip2 !== 10'h2AA) begin bad++; $display("FAIL reset_skip2 got=%0h exp=2aa", skip2); end
    total++; if ({valid, busy, done, last} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {valid, busy, done, last}); end
    byp1 = 10'h3C1;
    #1;
    total++; if (skip1 !== 10'h3C1) begin bad++; $display("FAIL bypass_comb got=%0h exp=3c1", skip1); end
    byp1 = 10'h155;
  endtask

  task automatic test_full_pass();
    int acc, nlast, errs;
    int t, x, y, e1, e2;
    acc = 0; nlast = 0; errs = 0;
    out_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < 512; b++) begin
      t = b / 64; x = (b / 8) % 8; y = b % 8;
      e1 = ((t / 2) * 8 + x) * 32 + (t % 2) * 16 + y;
      e2 = e1 + 8;
      if (int'(skip1) != e1 || int'(skip2) != e2 || valid !== 1'b1 || busy !== 1'b1) errs++;
      if (b == 0) begin
        total++; if (skip1 !== 10'd0 || skip2 !== 10'd8) begin bad++; $display("FAIL beat0 got=%0d/%0d exp=0/8", skip1, skip2); end
      end
      if (b == 1) begin
        total++; if (skip1 !== 10'd1 || skip2 !== 10'd9) begin bad++; $display("FAIL beat1 got=%0d/%0d exp=1/9", skip1, skip2); end
      end
      if (b == 8) begin
        total++; if (skip1 !== 10'd32 || skip2 !== 10'd40) begin bad++; $display("FAIL beat8 got=%0d/%0d exp=32/40", skip1, skip2); end
      end
      if (b == 64) begin
        total++; if (skip1 !== 10'd16 || skip2 !== 10'd24) begin bad++; $display("FAIL beat64 got=%0d/%0d exp=16/24", skip1, skip2); end
      end
      if (b == 128) begin
        total++; if (skip1 !== 10'd256 || skip2 !== 10'd264) begin bad++; $display("FAIL beat128 got=%0d/%0d exp=256/264", skip1, skip2); end
      end
      if (last === 1'b1) begin
        nlast++;
        total++; if (b != 511 || skip1 !== 10'd1015 || skip2 !== 10'd1023) begin bad++; $display("FAIL last_beat got=%0d:%0d/%0d exp=511:1015/1023", b, skip1, skip2); end
      end
      if (valid === 1'b1 && out_ready === 1'b1) acc++;
      tick();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL pass_sequence got=%0d bad beats exp=0", errs); end
    total++; if (acc != 512) begin bad++; $display("FAIL accept_count got=%0d exp=512", acc); end
    total++; if (nlast != 1) begin bad++; $display("FAIL last_count got=%0d exp=1", nlast); end
    total++; if ({done, busy, valid} !== 3'b100) begin bad++; $display("FAIL done_state got=%b exp=100", {done, busy, valid}); end
    total++; if (skip1 !== 10'h155 || skip2 !== 10'h2AA) begin bad++; $display("FAIL done_bypass got=%0h/%0h exp=155/2aa", skip1, skip2); end
    tick();
    total++; if ({done, busy, valid} !== 3'b000) begin bad++; $display("FAIL post_done got=%b exp=000", {done, busy, valid}); end
  endtask

  task automatic test_backpressure();
    int errs;
    errs = 0;
    out_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < 63; b++) tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (skip1 !== 10'd231 || skip2 !== 10'd239 || valid !== 1'b1 || last !== 1'b0) errs++;
      tick();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", errs); end
    total++; if (skip1 !== 10'd231 || skip2 !== 10'd239) begin bad++; $display("FAIL stall_beat63 got=%0d/%0d exp=231/239", skip1, skip2); end
    out_ready = 1'b1;
    tick();
    total++; if (skip1 !== 10'd16 || skip2 !== 10'd24) begin bad++; $display("FAIL release_beat64 got=%0d/%0d exp=16/24", skip1, skip2); end
    tick();
    total++; if (skip1 !== 10'd17 || skip2 !== 10'd25) begin bad++; $display("FAIL release_beat65 got=%0d/%0d exp=17/25", skip1, skip2); end
    do_reset();
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    out_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < 100; b++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (skip1 !== 10'd149 || skip2 !== 10'd157 || busy !== 1'b1) begin bad++; $display("FAIL start_in_run got=%0d/%0d busy=%b exp=149/157 busy=1", skip1, skip2, busy); end
    for (int b = 101; b < 200; b++) tick();
    total++; if (skip1 !== 10'd304 || skip2 !== 10'd312) begin bad++; $display("FAIL beat200 got=%0d/%0d exp=304/312", skip1, skip2); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({valid, busy, done} !== 3'b000 || skip1 !== 10'h155) begin bad++; $display("FAIL abort_idle got=%b/%0h exp=000/155", {valid, busy, done}, skip1); end
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    pulse_start();
    total++; if (skip1 !== 10'd0 || skip2 !== 10'd8 || valid !== 1'b1) begin bad++; $display("FAIL restart_beat0 got=%0d/%0d v=%b exp=0/8 v=1", skip1, skip2, valid); end
    do_reset();
  endtask

  task automatic test_param_16_4();
    int acc, nlast, seen_done;
    logic [7:0] l1, l2;
    acc = 0; nlast = 0; seen_done = 0; l1 = '0; l2 = '0;
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    total++; if (skip1_b !== 8'd0 || skip2_b !== 8'd4) begin bad++; $display("FAIL p16_beat0 got=%0d/%0d exp=0/4", skip1_b, skip2_b); end
    for (int c = 0; c < 200 && seen_done == 0; c++) begin
      if (valid_b === 1'b1 && ready_b === 1'b1) begin
        acc++;
        if (last_b === 1'b1) begin nlast++; l1 = skip1_b; l2 = skip2_b; end
      end
      if (done_b === 1'b1) seen_done = 1;
      tick();
    end
    total++; if (seen_done != 1) begin bad++; $display("FAIL p16_done got=%0d exp=1", seen_done); end
    total++; if (acc != 128) begin bad++; $display("FAIL p16_accepts got=%0d exp=128", acc); end
    total++; if (nlast != 1) begin bad++; $display("FAIL p16_last_count got=%0d exp=1", nlast); end
    total++; if (l1 !== 8'd251 || l2 !== 8'd255) begin bad++; $display("FAIL p16_last_pair got=%0d/%0d exp=251/255", l1, l2); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; byp1 = '0; byp2 = '0;
    start_b = 1'b0; ready_b = 1'b0; byp1_b = 8'h5A; byp2_b = 8'hA5;
    test_reset();
    test_full_pass();
    test_backpressure();
    test_abort();
    test_param_16_4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
